// File: rtl/gbsha_sample_packer.sv
// Packs BW-bit samples LSB-first into WORD_W-bit words and buffers them in a show-ahead FIFO.
// Push on the completing/flush edge; word_valid follows one edge later when the FIFO was empty.
module gbsha_sample_packer #(
  parameter int BW         = 2,
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [BW-1:0]                      sample_in,
  input  logic                               sample_valid,
  input  logic                               flush,
  output logic [WORD_W-1:0]                  word_out,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic [$clog2(WORD_W/BW)-1:0]       fill,
  output logic [$clog2(FIFO_DEPTH):0]        level,
  output logic                               overflow
);

  localparam int SPW    = WORD_W / BW;
  localparam int FILL_W = $clog2(SPW);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(SPW - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);

  logic [WORD_W-1:0] partial;
  logic [WORD_W-1:0] packed_word;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              complete;
  logic              push;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              drop;

  // The incoming sample is merged before the push decision so a flush on the
  // same edge includes it; unused upper slots stay zero because partial clears on push.
  always_comb begin
    packed_word = partial;
    if (sample_valid) begin
      packed_word[int'(fill)*BW +: BW] = sample_in;
    end
  end

  assign complete = sample_valid && (fill == LAST_SLOT);
  assign push     = complete || (flush && (sample_valid || (fill != '0)));
  assign pop      = word_valid && word_ready;
  assign full     = (level == FULL_LVL);
  assign push_ok  = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      partial <= '0;
      fill    <= '0;
    end else if (push) begin
      partial <= '0;
      fill    <= '0;
    end else if (sample_valid) begin
      partial <= packed_word;
      fill    <= fill + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      overflow <= overflow | drop;
    end
  end

  // Storage needs no reset: entries are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= packed_word;
  end

  assign word_valid = (level != '0);
  assign word_out   = word_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_gbsha_sample_packer.sv
// Directed and random stimulus for gbsha_sample_packer, checked against a queue-based model.
module tb_gbsha_sample_packer;
  localparam int BW = 2;
  localparam int WORD_W = 8;
  localparam int DEPTH = 4;
  localparam int SPW = WORD_W / BW;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sample_in;
  logic        sample_valid;
  logic        flush;
  logic [7:0]  word_out;
  logic        word_valid;
  logic        word_ready;
  logic [1:0]  fill;
  logic [2:0]  level;
  logic        overflow;

  int checks = 0;
  int passed = 0;

  logic [7:0] mq[$];
  int         ps[$];
  bit         movf;

  gbsha_sample_packer #(.BW(BW), .WORD_W(WORD_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .flush(flush), .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .fill(fill), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    ps.delete();
    movf = 1'b0;
  endtask

  task automatic model_edge(input logic sv, input logic [1:0] s, input logic fl, input logic rdy);
    bit do_pop;
    bit do_push;
    logic [7:0] w;
    do_pop  = (mq.size() > 0) && rdy;
    do_push = 1'b0;
    w = '0;
    if (sv) ps.push_back(int'(s));
    if (ps.size() == SPW || (fl && ps.size() > 0)) begin
      foreach (ps[i]) w = w | (8'(ps[i]) << (i * BW));
      do_push = 1'b1;
      ps.delete();
    end
    if (do_push && mq.size() == DEPTH && !do_pop) begin
      movf = 1'b1;
      do_push = 1'b0;
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(w);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".word_valid"}, 32'(word_valid), 32'(mq.size() > 0));
    chk({tag, ".word_out"}, 32'(word_out), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, ".fill"}, 32'(fill), 32'(ps.size()));
    chk({tag, ".level"}, 32'(level), 32'(mq.size()));
    chk({tag, ".overflow"}, 32'(overflow), 32'(movf));
  endtask

  // Called just after a rising edge; drives inputs, waits one edge, then checks.
  task automatic step(input string tag, input logic sv, input logic [1:0] s,
                      input logic fl, input logic rdy);
    sample_valid = sv;
    sample_in    = s;
    flush        = fl;
    word_ready   = rdy;
    @(posedge clk);
    model_edge(sv, s, fl, rdy);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; sample_in = '0; sample_valid = 1'b0; flush = 1'b0; word_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Basic packing: 1,2,3,0 -> 0x39
    step("t1a", 1, 2'd1, 0, 1);
    step("t1b", 1, 2'd2, 0, 1);
    step("t1c", 1, 2'd3, 0, 1);
    step("t1d", 1, 2'd0, 0, 1);
    chk("t1.word", 32'(word_out), 32'h39);
    chk("t1.valid", 32'(word_valid), 32'd1);
    step("t1e", 0, 2'd0, 0, 1);
    chk("t1.level0", 32'(level), 32'd0);

    // Flush of partial word 3,1 -> 0x07; flush with fill=0 is a no-op
    step("t2a", 1, 2'd3, 0, 0);
    step("t2b", 1, 2'd1, 0, 0);
    step("t2c", 0, 2'd0, 1, 0);
    chk("t2.word", 32'(word_out), 32'h07);
    chk("t2.fill", 32'(fill), 32'd0);
    step("t2d", 0, 2'd0, 1, 0);
    chk("t2.level", 32'(level), 32'd1);
    step("t2e", 0, 2'd0, 0, 1);

    // Flush together with completing sample: single 0x6A
    step("t3a", 1, 2'd2, 0, 0);
    step("t3b", 1, 2'd2, 0, 0);
    step("t3c", 1, 2'd2, 0, 0);
    step("t3d", 1, 2'd1, 1, 0);
    chk("t3.word", 32'(word_out), 32'h6A);
    chk("t3.level", 32'(level), 32'd1);
    step("t3e", 0, 2'd0, 0, 1);

    // Fill FIFO, then complete a word while popping: no overflow
    for (int i = 0; i < 4 * SPW + SPW - 1; i++) step("t5fill", 1, 2'(i), 0, 0);
    step("t5pp", 1, 2'd2, 0, 1);
    chk("t5.level", 32'(level), 32'd4);
    chk("t5.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) step("t5drain", 0, 2'd0, 0, 1);

    // Overflow: 5 full words into a 4-deep FIFO
    for (int i = 0; i < 5 * SPW; i++) step("t4fill", 1, 2'd3, 0, 0);
    chk("t4.level", 32'(level), 32'd4);
    chk("t4.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4.word", 32'(word_out), 32'hFF);
      step("t4drain", 0, 2'd0, 0, 1);
    end
    chk("t4.empty", 32'(word_valid), 32'd0);
    chk("t4.ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset between edges with fill=2, level=3
    for (int i = 0; i < 3 * SPW + 2; i++) step("t6fill", 1, 2'(i + 1), 0, 0);
    chk("t6.pre_fill", 32'(fill), 32'd2);
    chk("t6.pre_level", 32'(level), 32'd3);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("t6.fill", 32'(fill), 32'd0);
    chk("t6.level", 32'(level), 32'd0);
    chk("t6.valid", 32'(word_valid), 32'd0);
    chk("t6.ovf", 32'(overflow), 32'd0);
    chk("t6.word", 32'(word_out), 32'd0);
    #1 reset = 1'b0;
    step("t6a", 1, 2'd0, 0, 0);
    step("t6b", 1, 2'd1, 0, 0);
    step("t6c", 1, 2'd2, 0, 0);
    step("t6d", 1, 2'd3, 0, 0);
    chk("t6.fresh", 32'(word_out), 32'hE4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/gbsha_sample_packer.md
Name: gbsha_sample_packer

Overview:
- Output-side capture block for the FIR sample path.
- Collects a stream of narrow BW-bit samples, as produced on the delay-line pins, and packs them LSB-first into WORD_W-bit words.
- Buffers the words in a small show-ahead FIFO and presents them on a valid/ready interface, so a slow host or scan-chain reader can drain results without losing samples.
- Sits between the FIR core output and the readout logic.

Parameters:
- BW, 2, sample width in bits.
- WORD_W, 8, packed word width; must be a multiple of BW, with SPW = WORD_W/BW >= 2.
- FIFO_DEPTH, 4, number of word entries; power of 2, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_in  input  BW  sample data.
- sample_valid  input  1  sample_in is accepted on this edge; there is no backpressure.
- flush  input  1  pad a partial word with zeros and push it.
- word_out  output  WORD_W  FIFO head word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts word_out on this edge when word_valid=1.
- fill  output  clog2(SPW)  number of samples held in the partial word.
- level  output  clog2(FIFO_DEPTH)+1  number of FIFO entries.
- overflow  output  1  sticky: at least one completed word was dropped.

Behaviour:
- Reset (async assert, sync release):
  - fill=0, partial register=0, FIFO empty, level=0, word_valid=0.
  - word_out=0, overflow=0.
  - Reset asserted mid-word or with a non-empty FIFO discards everything immediately.
- Packing:
  - A sample accepted at fill=k is placed in partial bits [k*BW +: BW]; fill then increments.
  - When sample_valid=1 and fill=SPW-1, the completed word ({sample_in, partial[WORD_W-BW-1:0]}) is pushed on that edge; fill wraps to 0 and partial clears.
- Flush:
  - Case flush=1, sample_valid=0, fill>0: push the partial word, upper slots zero; fill becomes 0.
  - Case flush=1, sample_valid=1: the sample is included first. If that completes the word, push normally with no extra push; otherwise push the zero-padded word and set fill to 0.
  - Case flush=1, sample_valid=0, fill=0: no-op, no empty word is pushed.
- FIFO:
  - Show-ahead: word_out always equals the head entry, or 0 when empty.
  - Pop occurs when word_valid && word_ready.
  - Latency: a word pushed at edge N has word_valid=1 after edge N when the FIFO was empty.
  - Pop and push on the same edge: both happen and level is unchanged. This includes the full case, which is not an overflow.
  - Push when level=FIFO_DEPTH and no pop: the word is dropped and overflow is set to 1. Overflow stays 1 until reset. FIFO contents and order are unaffected.
  - word_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH; level = write count minus read count.
- No combinational path from word_ready or sample_valid to any output. All outputs are registered or derived from registered state.

Test Plan:
- BW=2, WORD_W=8; samples 1,2,3,0 on consecutive cycles with word_ready=1 -> word_valid high one cycle after the 4th sample, word_out=0x39, then level returns to 0.
- Samples 3,1 then flush pulse -> one word 0x07 pushed, fill=0. A second flush with fill=0 -> level unchanged.
- Samples 2,2,2 then flush+sample 1 on the same cycle -> a single word 0x6A, no extra padded word.
- word_ready=0; push 5 full words (all samples=3) -> level=4, overflow=1, four 0xFF entries. Then drain with word_ready=1 -> exactly 4 words, overflow stays 1.
- FIFO full with word_ready=1 while the 4th sample of a new word arrives -> simultaneous pop/push, level stays 4, overflow stays 0.
- Assert reset asynchronously between edges with fill=2 and level=3 -> fill, level, word_valid and overflow go to 0 before the next edge. Samples after release start a fresh word.
